// File: rtl/std_div_pipe_if.sv
// Handshake and operand/result bundle between a controller and std_div_pipe.
// The controller drives go/left/right and consumes the results when done pulses.
interface std_div_pipe_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             done;

    modport master (
        output go,
        output left,
        output right,
        input  out_quotient,
        input  out_remainder,
        input  done
    );

    modport slave (
        input  go,
        input  left,
        input  right,
        output out_quotient,
        output out_remainder,
        output done
    );
endinterface

// File: rtl/std_div_pipe.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fixed
// latency of WIDTH+1 cycles from the go edge to the single-cycle done pulse.
module std_div_pipe #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    std_div_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg,    state_next;
    logic [CW-1:0]    count_reg,    count_next;
    logic [WIDTH:0]   rem_reg,      rem_next;
    logic [WIDTH-1:0] shq_reg,      shq_next;
    logic [WIDTH-1:0] dividend_reg, dividend_next;
    logic [WIDTH-1:0] divisor_reg,  divisor_next;
    logic [WIDTH-1:0] quot_reg,     quot_next;
    logic [WIDTH-1:0] remout_reg,   remout_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, and record the bit in Q.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             fits;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        rem_shift = {rem_reg[WIDTH-1:0], shq_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_reg};
        fits      = (rem_shift >= {1'b0, divisor_reg});
        rem_step  = fits ? rem_diff : rem_shift;
        q_step    = {shq_reg[WIDTH-2:0], fits};
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        rem_next      = rem_reg;
        shq_next      = shq_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        quot_next     = quot_reg;
        remout_next   = remout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.go) begin
                    state_next    = ST_RUN;
                    dividend_next = bus.left;
                    divisor_next  = bus.right;
                    shq_next      = bus.left;
                    rem_next      = '0;
                    count_next    = '0;
                end
            end
            ST_RUN: begin
                rem_next = rem_step;
                shq_next = q_step;
                if (count_reg == LAST) begin
                    state_next  = ST_DONE;
                    quot_next   = q_step;
                    remout_next = rem_step[WIDTH-1:0];
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            rem_reg      <= '0;
            shq_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            quot_reg     <= '0;
            remout_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            rem_reg      <= rem_next;
            shq_reg      <= shq_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            quot_reg     <= quot_next;
            remout_reg   <= remout_next;
        end
    end

    assign bus.out_quotient  = quot_reg;
    assign bus.out_remainder = remout_reg;
    assign bus.done          = (state_reg == ST_DONE);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("std_div_pipe: WIDTH must be at least 2");
        end
    endgenerate

    logic [2*WIDTH-1:0] check_sum;
    assign check_sum = ({{WIDTH{1'b0}}, quot_reg} * {{WIDTH{1'b0}}, divisor_reg})
                     + {{WIDTH{1'b0}}, remout_reg};

    always_ff @(posedge clk) begin
        if (!reset && bus.done && divisor_reg != '0) begin
            assert (check_sum == {{WIDTH{1'b0}}, dividend_reg})
                else $error("std_div_pipe: q*d+r does not equal the latched dividend");
        end
    end
endmodule

// File: tb/tb_std_div_pipe.sv
// Bench for std_div_pipe: WIDTH=32 and WIDTH=8 instances checked every cycle
// against a transaction-level latency/arithmetic model plus directed literals.
module tb_std_div_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    std_div_pipe_if #(.WIDTH(32)) bus32 ();
    std_div_pipe_if #(.WIDTH(8))  bus8 ();

    std_div_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    std_div_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Model state per instance (0 = WIDTH 32, 1 = WIDTH 8): m_t counts cycles
    // since the accepted go edge, 0 meaning idle.
    logic [63:0] m_q [2];
    logic [63:0] m_r [2];
    logic [63:0] m_pq[2];
    logic [63:0] m_pr[2];
    int          m_t [2];
    bit          m_done[2];

    function automatic int wid(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] maskw(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (one << w) - 64'd1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input bit rst, input bit g,
                              input logic [63:0] l, input logic [63:0] d);
        int w;
        w = wid(k);
        if (rst) begin
            m_t[k] = 0; m_q[k] = '0; m_r[k] = '0; m_done[k] = 1'b0;
        end else if (m_t[k] == 0) begin
            m_done[k] = 1'b0;
            if (g) begin
                if (d == 0) begin
                    m_pq[k] = maskw(w); m_pr[k] = l;
                end else begin
                    m_pq[k] = l / d; m_pr[k] = l % d;
                end
                m_t[k] = 1;
            end
        end else if (m_t[k] == w + 1) begin
            m_done[k] = 1'b0;
            m_t[k] = 0;
        end else begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == w + 1) begin
                m_q[k] = m_pq[k]; m_r[k] = m_pr[k]; m_done[k] = 1'b1;
            end
        end
    endtask

    task automatic drive(input int k, input bit g, input logic [63:0] l, input logic [63:0] d);
        if (k == 0) begin
            bus32.go = g; bus32.left = l[31:0]; bus32.right = d[31:0];
        end else begin
            bus8.go = g; bus8.left = l[7:0]; bus8.right = d[7:0];
        end
    endtask

    task automatic peek(input int k, output bit dn, output logic [63:0] q, output logic [63:0] r);
        if (k == 0) begin
            dn = bus32.done; q = {32'd0, bus32.out_quotient}; r = {32'd0, bus32.out_remainder};
        end else begin
            dn = bus8.done; q = {56'd0, bus8.out_quotient}; r = {56'd0, bus8.out_remainder};
        end
    endtask

    // Model advances on each rising edge from the inputs the DUTs sampled,
    // then outputs are compared on the following falling edge.
    initial begin
        bit          s_rst, s_g0, s_g1;
        logic [63:0] s_l0, s_d0, s_l1, s_d1;
        bit          dn;
        logic [63:0] q, r;
        forever begin
            @(posedge clk);
            s_rst = reset;
            s_g0 = bus32.go; s_l0 = {32'd0, bus32.left}; s_d0 = {32'd0, bus32.right};
            s_g1 = bus8.go;  s_l1 = {56'd0, bus8.left};  s_d1 = {56'd0, bus8.right};
            model_step(0, s_rst, s_g0, s_l0, s_d0);
            model_step(1, s_rst, s_g1, s_l1, s_d1);
            @(negedge clk);
            if (model_on) begin
                for (int k = 0; k < 2; k++) begin
                    peek(k, dn, q, r);
                    check((k == 0) ? "model_done32" : "model_done8", {63'd0, dn}, {63'd0, m_done[k]});
                    check((k == 0) ? "model_q32" : "model_q8", q, m_q[k]);
                    check((k == 0) ? "model_r32" : "model_r8", r, m_r[k]);
                end
            end
        end
    end

    task automatic wait_done(input int k, output int lat, output logic [63:0] q, output logic [63:0] r);
        bit dn;
        lat = 0; dn = 1'b0; q = '0; r = '0;
        while (!dn && lat < 200) begin
            @(negedge clk);
            lat++;
            peek(k, dn, q, r);
        end
        if (!dn) begin
            checks++; errors++;
            $display("FAIL done_timeout: instance %0d, no done within 200 cycles", k);
        end
    endtask

    task automatic run_op(input int k, input logic [63:0] l, input logic [63:0] d,
                          output int lat, output logic [63:0] q, output logic [63:0] r);
        @(negedge clk);
        drive(k, 1'b1, l, d);
        wait_done(k, lat, q, r);
        drive(k, 1'b0, '0, '0);
        $display("op inst=%0d %0d / %0d -> q=%0d r=%0d latency=%0d", k, l, d, q, r, lat);
    endtask

    initial begin
        int          lat;
        bit          dn;
        logic [63:0] q, r, l, d;

        reset = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        peek(0, dn, q, r);
        check("reset_done", {63'd0, dn}, 64'd0);
        check("reset_q", q, 64'd0);
        check("reset_r", r, 64'd0);
        reset = 1'b0;
        model_on = 1'b1;

        run_op(0, 100, 7, lat, q, r);
        check("lat_100_7", lat, 33); check("q_100_7", q, 14); check("r_100_7", r, 2);

        run_op(0, 5, 0, lat, q, r);
        check("lat_div0", lat, 33); check("q_div0", q, 64'hFFFF_FFFF); check("r_div0", r, 5);
        run_op(0, 64'hFFFF_FFFF, 1, lat, q, r);
        check("q_max_1", q, 64'hFFFF_FFFF); check("r_max_1", r, 0);
        run_op(0, 3, 9, lat, q, r);
        check("q_3_9", q, 0); check("r_3_9", r, 3);

        // Operands change mid-run; the latched ones must win.
        @(negedge clk);
        drive(0, 1'b1, 1000, 10);
        repeat (5) @(negedge clk);
        drive(0, 1'b1, 7, 1);
        peek(0, dn, q, r);
        check("hold_q_midrun", q, 0); check("hold_r_midrun", r, 3);
        wait_done(0, lat, q, r);
        lat += 5;
        drive(0, 1'b0, '0, '0);
        $display("op inst=0 1000 / 10 (changed mid-run) -> q=%0d r=%0d latency=%0d", q, r, lat);
        check("lat_change", lat, 33); check("q_change", q, 100); check("r_change", r, 0);

        // Reset in the middle of an operation aborts it silently.
        @(negedge clk);
        drive(0, 1'b1, 1234, 5);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        peek(0, dn, q, r);
        check("abort_done", {63'd0, dn}, 0); check("abort_q", q, 0); check("abort_r", r, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            peek(0, dn, q, r);
            check("abort_no_done", {63'd0, dn}, 0);
        end
        $display("op inst=0 1234 / 5 aborted by reset, no done seen");
        run_op(0, 50, 4, lat, q, r);
        check("lat_50_4", lat, 33); check("q_50_4", q, 12); check("r_50_4", r, 2);

        // Back-to-back with go held through DONE.
        @(negedge clk);
        drive(0, 1'b1, 17, 5);
        wait_done(0, lat, q, r);
        $display("op inst=0 17 / 5 -> q=%0d r=%0d latency=%0d", q, r, lat);
        check("lat_b2b_1", lat, 33); check("q_17_5", q, 3); check("r_17_5", r, 2);
        drive(0, 1'b1, 64, 8);
        wait_done(0, lat, q, r);
        drive(0, 1'b0, '0, '0);
        $display("op inst=0 64 / 8 -> q=%0d r=%0d gap=%0d", q, r, lat);
        check("gap_b2b", lat, 34); check("q_64_8", q, 8); check("r_64_8", r, 0);

        run_op(1, 200, 3, lat, q, r);
        check("lat_w8", lat, 9); check("q_200_3", q, 66); check("r_200_3", r, 2);
        run_op(1, 77, 0, lat, q, r);
        check("q_w8_div0", q, 64'hFF); check("r_w8_div0", r, 77);

        for (int i = 0; i < 200; i++) begin
            l = 64'($urandom_range(0, 255));
            d = (i % 25 == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            run_op(1, l, d, lat, q, r);
            if (d != 0) begin
                check("w8_identity", q * d + r, l);
                check("w8_rem_lt_div", {63'd0, r < d}, 64'd1);
            end else begin
                check("w8_div0_q", q, 64'hFF);
                check("w8_div0_r", r, l);
            end
        end
        for (int i = 0; i < 40; i++) begin
            l = 64'($urandom);
            d = 64'($urandom >> $urandom_range(0, 31));
            run_op(0, l, d, lat, q, r);
            check("w32_lat", lat, 33);
            if (d != 0) begin
                check("w32_identity", q * d + r, l);
                check("w32_rem_lt_div", {63'd0, r < d}, 64'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
